// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, mux selects, opcodes.
// Latency: n/a (types, constants and one pure decode function).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_TRAP = 3'd5
  } state_e;

  // Also the select encoding consumed by the immediate extender.
  typedef enum logic [2:0] {
    IMM_I      = 3'd0,
    IMM_ISHAMT = 3'd1,
    IMM_S      = 3'd2,
    IMM_B      = 3'd3,
    IMM_U      = 3'd4,
    IMM_J      = 3'd5
  } imm_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic [3:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_LUI, CL_AUIPC,
    CL_BRANCH, CL_JAL, CL_JALR, CL_ILL
  } class_e;

  // inst[6:2] opcode values
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  function automatic class_e op_class(input logic [4:0] opc);
    case (opc)
      OPC_OP, OPC_OPIMM: return CL_ALU;
      OPC_LOAD:          return CL_LOAD;
      OPC_STORE:         return CL_STORE;
      OPC_LUI:           return CL_LUI;
      OPC_AUIPC:         return CL_AUIPC;
      OPC_BRANCH:        return CL_BRANCH;
      OPC_JAL:           return CL_JAL;
      OPC_JALR:          return CL_JALR;
      default:           return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Combinational opcode/funct3 -> instruction class and immediate format decode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: opcode = inst[6:2], funct3 = inst[14:12]; cls = class (CL_ILL if unsupported),
//        imm_sel = immediate format for the extender.
module multicycle_ctrl_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] funct3,
  output class_e     cls,
  output imm_sel_e   imm_sel
);

  always_comb begin
    cls     = op_class(opcode);
    imm_sel = IMM_I;
    case (cls)
      // Shift-immediates carry a 5-bit shamt, not a sign-extended imm.
      CL_ALU:           if (opcode == OPC_OPIMM && (funct3 == 3'b001 || funct3 == 3'b101))
                          imm_sel = IMM_ISHAMT;
      CL_STORE:         imm_sel = IMM_S;
      CL_BRANCH:        imm_sel = IMM_B;
      CL_LUI, CL_AUIPC: imm_sel = IMM_U;
      CL_JAL:           imm_sel = IMM_J;
      default:          imm_sel = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM (IF/ID/EX/MEM/WB/TRAP) driving datapath strobes and mux selects.
// Latency: ALU/LUI/AUIPC/JAL/JALR 4, load 5, store 4, branch 3 cycles with zero-wait acks.
// Backpressure: IF holds imem_req until imem_ack, MEM holds dmem_req until dmem_ack; stray acks ignored.
// Ports: clk, rst (sync, active-high); inst = IR contents; imem_ack/dmem_ack/br_taken inputs;
//        imem_req, ir_we, pc_we, pc_sel, imm_sel, alu_a_sel, alu_b_sel, reg_we, dmem_req, dmem_we,
//        wb_sel, illegal (sticky), state_o. Define CTRL_PERF_CNT_EN to add cycle_cnt/retired_cnt.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  state_e     state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  imm_sel_e   imm_sel_q, imm_sel_d;
  logic       illegal_q, illegal_d;

  class_e     dec_cls;
  imm_sel_e   dec_imm_sel;
  class_e     cls_q;

  // Only opcode and funct3 matter to control; the rest of the IR feeds the datapath.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[31:15], inst[11:7], inst[1:0]};

  multicycle_ctrl_dec u_dec (
    .opcode  (inst[6:2]),
    .funct3  (inst[14:12]),
    .cls     (dec_cls),
    .imm_sel (dec_imm_sel)
  );

  assign cls_q   = op_class(opcode_q);
  // Live decode while in ID, then the latched format for the rest of the instruction.
  assign imm_sel = (state_q == ST_ID) ? dec_imm_sel : imm_sel_q;
  assign illegal = illegal_q;
  assign state_o = state_q;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    imm_sel_d = imm_sel_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    reg_we    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    wb_sel    = WB_ALU;

    // Requests and strobes stay low while rst is held, so the first fetch
    // request appears only in the first cycle after release.
    if (!rst) begin
      case (state_q)
        ST_IF: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = ST_ID;
          end
        end
        ST_ID: begin
          opcode_d  = inst[6:2];
          imm_sel_d = dec_imm_sel;
          if (dec_cls == CL_ILL) begin
            illegal_d = 1'b1;
            state_d   = ST_TRAP;
          end else begin
            state_d = ST_EX;
          end
        end
        ST_EX: begin
          case (cls_q)
            CL_ALU: begin
              alu_b_sel = (opcode_q == OPC_OPIMM);
              state_d   = ST_WB;
            end
            CL_LOAD, CL_STORE: begin
              alu_b_sel = 1'b1;
              state_d   = ST_MEM;
            end
            CL_LUI: begin
              alu_b_sel = 1'b1;
              state_d   = ST_WB;
            end
            CL_AUIPC, CL_JAL: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
              state_d   = ST_WB;
            end
            CL_JALR: begin
              alu_b_sel = 1'b1;
              state_d   = ST_WB;
            end
            CL_BRANCH: begin
              pc_we   = br_taken;
              pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
              state_d = ST_IF;
            end
            default: begin
              illegal_d = 1'b1;
              state_d   = ST_TRAP;
            end
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CL_STORE);
          if (dmem_ack) begin
            if (cls_q == CL_STORE) begin
              pc_we   = 1'b1;
              state_d = ST_IF;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_IF;
          case (cls_q)
            CL_JAL:  begin pc_sel = PC_IMM; wb_sel = WB_PC4; end
            CL_JALR: begin pc_sel = PC_ALU; wb_sel = WB_PC4; end
            CL_LOAD: wb_sel = WB_LOAD;
            CL_LUI:  wb_sel = WB_IMM;
            default: wb_sel = WB_ALU;
          endcase
        end
        default: state_d = ST_TRAP;  // TRAP is absorbing; only rst leaves it
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IF;
      opcode_q  <= 5'd0;
      imm_sel_q <= IMM_I;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      imm_sel_q <= imm_sel_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic        retire;

  // An instruction retires on its final state exit: WB, store MEM ack, or branch EX.
  assign retire = (state_q == ST_WB)
               || (state_q == ST_MEM && dmem_ack && cls_q == CL_STORE)
               || (state_q == ST_EX && cls_q == CL_BRANCH);

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 32'd1;
    retired_cnt_d = retired_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= 32'd0;
      retired_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues its hand-computed outputs.
// Latency: monitor compares on the falling edge of the same cycle the vector was driven.
// Backpressure: acks are driven directly per vector, including delayed and stray acks.
module tb_multicycle_ctrl;

  localparam logic [2:0] SIF = 3'd0, SID = 3'd1, SEX = 3'd2, SMEM = 3'd3, SWB = 3'd4, STRAP = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       ireq;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcsel;
    logic [2:0] imm;
    logic       a;
    logic       b;
    logic       rwe;
    logic       dreq;
    logic       dwe;
    logic [1:0] wb;
    logic       ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        imem_ack, dmem_ack, br_taken;
  logic        imem_req, ir_we, pc_we, alu_a_sel, alu_b_sel, reg_we, dmem_req, dmem_we, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .br_taken  (br_taken),
    .imem_req  (imem_req),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .imm_sel   (imm_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .reg_we    (reg_we),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .state_o   (state_o)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  function automatic exp_t ex(input logic [2:0] st, input logic ireq, irwe, pcwe,
                              input logic [1:0] pcsel, input logic [2:0] imm,
                              input logic a, b, rwe, dreq, dwe, input logic [1:0] wb,
                              input logic ill);
    exp_t e;
    e.st = st; e.ireq = ireq; e.irwe = irwe; e.pcwe = pcwe; e.pcsel = pcsel; e.imm = imm;
    e.a = a; e.b = b; e.rwe = rwe; e.dreq = dreq; e.dwe = dwe; e.wb = wb; e.ill = ill;
    return e;
  endfunction

  // One clock cycle of stimulus plus the outputs expected during it.
  task automatic cyc(input string nm, input logic r, ia, da, bt, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; imem_ack = ia; dmem_ack = da; br_taken = bt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // addi x1,x0,5 with immediate acks (imem_ack left high to show stray acks are ignored).
  task automatic addi_seq(input string tag);
    inst = 32'h00500093;
    cyc({tag, ".if"}, 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc({tag, ".id"}, 0, 1, 0, 0, ex(SID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc({tag, ".ex"}, 0, 1, 0, 0, ex(SEX, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc({tag, ".wb"}, 0, 1, 0, 0, ex(SWB, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
  endtask

  // Monitor: pop and compare whenever a vector is outstanding.
  initial begin
    exp_t  e, got;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = ex(state_o, imem_req, ir_we, pc_we, pc_sel, imm_sel, alu_a_sel, alu_b_sel,
                 reg_we, dmem_req, dmem_we, wb_sel, illegal);
        n_vec++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL %s: got st/ireq/irwe/pcwe/pcsel/imm/a/b/rwe/dreq/dwe/wb/ill=%b expected %b",
                   nm, got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got %0d vectors expected completion", n_vec);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inst = 32'd0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;

    // Stray acks during reset must not fetch or load the IR.
    cyc("reset", 1, 1, 1, 0, ex(SIF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addi_seq("addi");

    // lw x1,0(x0), dmem_ack three cycles late: 8 cycles total
    inst = 32'h00002083;
    cyc("lw.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw.id", 0, 0, 1, 0, ex(SID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw.ex", 0, 0, 1, 0, ex(SEX, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc("lw.mem_wait", 0, 0, 0, 0, ex(SMEM, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("lw.mem_ack", 0, 0, 1, 0, ex(SMEM, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("lw.wb", 0, 0, 0, 0, ex(SWB, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));

    // sw x1,4(x0), one imem wait state
    inst = 32'h00102223;
    cyc("sw.if_wait", 0, 0, 0, 0, ex(SIF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw.id", 0, 0, 0, 0, ex(SID, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw.ex", 0, 0, 0, 0, ex(SEX, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0));
    cyc("sw.mem", 0, 0, 1, 0, ex(SMEM, 0, 0, 1, 0, 2, 0, 0, 0, 1, 1, 0, 0));

    // beq x0,x0,8 taken, then not taken
    inst = 32'h00000463;
    cyc("beq_t.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    cyc("beq_t.id", 0, 0, 0, 1, ex(SID, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    cyc("beq_t.ex", 0, 0, 0, 1, ex(SEX, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    cyc("beq_n.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    cyc("beq_n.id", 0, 0, 0, 0, ex(SID, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    cyc("beq_n.ex", 0, 0, 0, 0, ex(SEX, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));

    // slli x1,x1,2
    inst = 32'h00209093;
    cyc("slli.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    cyc("slli.id", 0, 0, 0, 0, ex(SID, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("slli.ex", 0, 0, 0, 0, ex(SEX, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    cyc("slli.wb", 0, 0, 0, 0, ex(SWB, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));

    // jal x1,8
    inst = 32'h008000EF;
    cyc("jal.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("jal.id", 0, 0, 0, 0, ex(SID, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    cyc("jal.ex", 0, 0, 0, 0, ex(SEX, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0));
    cyc("jal.wb", 0, 0, 0, 0, ex(SWB, 0, 0, 1, 1, 5, 0, 0, 1, 0, 0, 2, 0));

    // jalr x1,0(x2)
    inst = 32'h000100E7;
    cyc("jalr.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    cyc("jalr.id", 0, 0, 0, 0, ex(SID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jalr.ex", 0, 0, 0, 0, ex(SEX, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc("jalr.wb", 0, 0, 0, 0, ex(SWB, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 2, 0));

    // lui x1,0x12345
    inst = 32'h123450B7;
    cyc("lui.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lui.id", 0, 0, 0, 0, ex(SID, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    cyc("lui.ex", 0, 0, 0, 0, ex(SEX, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0));
    cyc("lui.wb", 0, 0, 0, 0, ex(SWB, 0, 0, 1, 0, 4, 0, 0, 1, 0, 0, 3, 0));

    // lw aborted by rst while waiting in MEM
    inst = 32'h00002083;
    cyc("lwrst.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwrst.id", 0, 0, 0, 0, ex(SID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwrst.ex", 0, 0, 0, 0, ex(SEX, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc("lwrst.mem", 0, 0, 0, 0, ex(SMEM, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("lwrst.rst", 1, 0, 0, 0, ex(SMEM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwrst.after", 0, 0, 0, 0, ex(SIF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Unsupported opcode 0x7F traps; trap ignores every input for 10 cycles
    inst = 32'h0000007F;
    cyc("trap.if", 0, 1, 0, 0, ex(SIF, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("trap.id", 0, 0, 0, 0, ex(SID, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      cyc("trap.hold", 0, 1, 1, 1, ex(STRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc("trap.rst", 1, 0, 0, 0, ex(STRAP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Three addi straight out of reset
    addi_seq("addi1");
    addi_seq("addi2");
    addi_seq("addi3");
    cyc("idle", 0, 0, 0, 0, ex(SIF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef CTRL_PERF_CNT_EN
    n_vec++;
    if (cycle_cnt !== 32'd12) begin
      n_bad++;
      $display("FAIL cycle_cnt: got %0d expected 12", cycle_cnt);
    end
    n_vec++;
    if (retired_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL retired_cnt: got %0d expected 3", retired_cnt);
    end
`endif

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending vectors expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port inst  input  32  instruction register contents; decodes inst[6:2] and inst[14:12].
REQ-004 SHALL have port imem_ack  input  1  instruction memory data valid for the current request.
REQ-005 SHALL have port dmem_ack  input  1  data memory access complete.
REQ-006 SHALL have port br_taken  input  1  branch compare result from ALU, valid in EX.
REQ-007 SHALL have port imem_req  output  1  instruction fetch request.
REQ-008 SHALL have port ir_we  output  1  instruction register load strobe.
REQ-009 SHALL have port pc_we  output  1  PC update strobe.
REQ-010 SHALL have port pc_sel  output  2  next PC: 0=PC+4, 1=PC+imm, 2=ALU result (JALR).
REQ-011 SHALL have port imm_sel  output  3  immediate format: 0=I, 1=I-shamt, 2=S, 3=B, 4=U, 5=J.
REQ-012 SHALL have port alu_a_sel / alu_b_sel  output  1 each  a: 0=rs1, 1=PC; b: 0=rs2, 1=imm.
REQ-013 SHALL have port reg_we  output  1  register file write strobe.
REQ-014 SHALL have port dmem_req / dmem_we  output  1 each  data access request and write qualifier.
REQ-015 SHALL have port wb_sel  output  2  writeback source: 0=ALU, 1=load data, 2=PC+4, 3=imm.
REQ-016 SHALL have port illegal  output  1  sticky unsupported-opcode flag.
REQ-017 SHALL have port state_o  output  3  current FSM state, for debug.

Function
REQ-018 SHALL implement the states IF, ID, EX, MEM, WB and TRAP as an FSM.
REQ-019 In IF: imem_req=1 held until imem_ack; on the ack cycle ir_we=1 and the FSM moves to ID; without ack it stays in IF.
REQ-020 In ID: imm_sel is decoded from the opcode:
- 00000, 11001 → I
- 00100 → I, except funct3 001/101 → I-shamt
- 01000 → S; 11000 → B; 01101, 00101 → U; 11011 → J
- any other opcode → TRAP
REQ-021 The decoded opcode and imm_sel SHALL be registered in ID and held stable through the end of the instruction.
REQ-022 In EX, per class:
- R/I-ALU → WB
- load/store → MEM
- LUI/AUIPC → WB
- B: pc_we=br_taken, pc_sel=1 when taken, then IF
- JAL: alu_a_sel=1 → WB
- JALR: alu_a_sel=0 → WB
REQ-023 In MEM: dmem_req=1 (dmem_we=1 for store) held until dmem_ack; on ack a load → WB and a store → IF with pc_we=1, pc_sel=0.
REQ-024 In WB: reg_we=1 for exactly one cycle and pc_we=1, then IF.
- JAL: pc_sel=1
- JALR: pc_sel=2
- otherwise: pc_sel=0
- wb_sel: ALU, load=1, JAL/JALR=2, LUI=3
REQ-025 Latency in cycles, with zero-wait acks:
- ALU/LUI/AUIPC/JAL/JALR: 4
- load: 5
- store: 4
- branch: 3
REQ-026 Every strobe (ir_we, pc_we, reg_we, dmem_req) SHALL be 0 in every state not listed above for it.
REQ-027 TRAP SHALL be absorbing: illegal=1, all strobes 0, exit only by rst.
REQ-028 An ack arriving in a state that is not waiting for it SHALL be ignored.

Reset
REQ-029 rst SHALL force state=IF, all strobes 0, illegal=0, registered opcode/imm_sel=0, on the next edge, including mid-wait in IF or MEM.
REQ-030 The first fetch request SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-031 With CTRL_PERF_CNT_EN defined, SHALL add outputs cycle_cnt[31:0] and retired_cnt[31:0], both reset to 0.
- cycle_cnt increments every non-reset cycle.
- retired_cnt increments on each WB exit, store MEM exit, and branch EX exit.
- Both wrap modulo 2^32.
REQ-032 Without CTRL_PERF_CNT_EN, the counters and their ports SHALL be absent.

Structure
REQ-033 A shared package SHALL hold the state enum, the imm_sel/pc_sel/wb_sel enums, and the opcode[6:2] constants; the immediate extender SHALL consume the same imm_sel encoding.
REQ-034 The combinational opcode-to-class/imm_sel decode SHALL be a sub-module, multicycle_ctrl_dec.

Verification
REQ-035 addi x1,x0,5 (0x00500093), acks immediate → IF,ID,EX,WB; imm_sel=0, reg_we=1 in cycle 4 only, pc_sel=0.
REQ-036 lw with dmem_ack delayed 3 cycles → dmem_req held 4 cycles in MEM, then WB with wb_sel=1, total 8 cycles.
REQ-037 beq with br_taken=1 → pc_we=1, pc_sel=1 in EX, no reg_we; with br_taken=0 → pc_we=0, return to IF.
REQ-038 slli (0x00209093) → imm_sel=1; jal (0x008000EF) → imm_sel=5, wb_sel=2, pc_sel=1.
REQ-039 Opcode 0x7F → TRAP, illegal=1 persists 10 cycles; rst for 1 cycle → IF, illegal=0.
REQ-040 rst asserted mid-MEM wait → next cycle state=IF, dmem_req=0; with CTRL_PERF_CNT_EN, three addi instructions → retired_cnt=3, cycle_cnt=12.
